fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit feeding decode.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   input  logic        i_instr_ready,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_stall_cnt
);

   // Handshakes: a memory request transfers when o_imem_req && i_imem_gnt;
   // an instruction transfers to decode when o_instr_valid && i_instr_ready,
   // and the offered instruction/pc stay stable until that transfer.

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  buf_q, buf_d;
   logic         drop_q, drop_d;
   logic         req_w;
   logic         handshake_w;

   // A stale response is still owed while drop_q is set, so no new request.
   assign req_w       = (state_q == S_REQ) && !drop_q;
   assign handshake_w = (state_q == S_HOLD) && i_instr_ready && !i_redirect;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (i_redirect) begin
         state_d = S_REQ;
      end else begin
         case (state_q)
            S_REQ:   if (req_w && i_imem_gnt) state_d = S_WAIT;
            S_WAIT:  if (i_imem_rvalid)       state_d = S_HOLD;
            S_HOLD:  if (i_instr_ready)       state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end
   end

   // Output logic; reset masks the registered values during the reset cycle
   always_comb begin
      o_imem_req    = req_w && !i_rst;
      o_instr_valid = (state_q == S_HOLD) && !i_rst;
      o_instr       = i_rst ? 32'h0 : buf_q;
      o_pc          = i_rst ? RESET_PC : pc_q;
      o_imem_addr   = o_pc;
      o_pc_plus4    = o_pc + 32'd4;
   end

   // Datapath: pc, instruction buffer and stale-response drop flag
   always_comb begin
      pc_d   = pc_q;
      buf_d  = buf_q;
      drop_d = drop_q;
      if (i_redirect) begin
         pc_d   = i_redirect_pc;
         buf_d  = 32'h0;
         drop_d = ((state_q == S_WAIT) && !i_imem_rvalid)
                | (req_w && i_imem_gnt)
                | (drop_q && !i_imem_rvalid);
      end else begin
         if (drop_q && i_imem_rvalid) begin
            drop_d = 1'b0;
         end
         if ((state_q == S_WAIT) && i_imem_rvalid) begin
            buf_d = i_imem_rdata;
         end
         if (handshake_w) begin
            pc_d = pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_q   <= RESET_PC;
         buf_q  <= 32'h0;
         drop_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         buf_q  <= buf_d;
         drop_q <= drop_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (handshake_w) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (o_instr_valid && !i_instr_ready) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_fetch_cnt = fetch_cnt_q;
   assign o_stall_cnt = stall_cnt_q;
`else
   assign o_fetch_cnt = 32'h0;
   assign o_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus corner-case sequences.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_ready;
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_gnt    (imem_gnt),
      .i_imem_rvalid (imem_rvalid),
      .i_imem_rdata  (imem_rdata),
      .o_instr_valid (instr_valid),
      .o_instr       (instr),
      .o_pc          (pc),
      .o_pc_plus4    (pc_plus4),
      .i_instr_ready (instr_ready),
      .o_fetch_cnt   (fetch_cnt),
      .o_stall_cnt   (stall_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic rd, logic [31:0] rp, logic g, logic rv,
                               logic [31:0] dat, logic rdy, logic e_req, logic [31:0] e_pc,
                               logic e_val, logic [31:0] e_ins);
      vec_t v;
      v.rst = r; v.redir = rd; v.rpc = rp; v.gnt = g; v.rvalid = rv;
      v.rdata = dat; v.ready = rdy; v.exp_req = e_req; v.exp_pc = e_pc;
      v.exp_valid = e_val; v.exp_instr = e_ins;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // driver: apply one cycle of inputs at negedge, settle before checking
   task automatic cyc(input logic r, input logic rd, input logic [31:0] rp, input logic g,
                      input logic rv, input logic [31:0] dat, input logic rdy);
      @(negedge clk);
      rst = r; redirect = rd; redirect_pc = rp; imem_gnt = g;
      imem_rvalid = rv; imem_rdata = dat; instr_ready = rdy;
      #1;
   endtask

   task automatic chk_core(input string tag, input logic e_req, input logic [31:0] e_pc,
                           input logic e_val);
      chk({tag, ".req"},   {31'h0, imem_req},    {31'h0, e_req});
      chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, e_val});
      chk({tag, ".pc"},    pc, e_pc);
      chk({tag, ".pc4"},   pc_plus4, e_pc + 32'd4);
      if (e_req) chk({tag, ".addr"}, imem_addr, e_pc);
   endtask

   initial begin
      logic [31:0] exp_stall;
      logic [31:0] exp_fetch;
      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;

      // streaming, redirect-with-drop and redirect-priority vectors
      vecs.push_back(mk(1,0,32'h0  ,0,0,32'h0       ,0, 0,32'h0  ,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 1,32'h0  ,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 0,32'h0  ,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 0,32'h0  ,1,NOP));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 1,32'h4  ,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 0,32'h4  ,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 0,32'h4  ,1,NOP));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 1,32'h8  ,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 0,32'h8  ,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,NOP         ,1, 0,32'h8  ,1,NOP));
      vecs.push_back(mk(0,0,32'h0  ,1,0,32'h0       ,1, 1,32'hC  ,0,32'h0));
      vecs.push_back(mk(0,1,32'h100,0,0,32'h0       ,1, 0,32'hC  ,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,0,0,32'h0       ,1, 0,32'h100,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,32'hBAD0BAD0,1, 0,32'h100,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,0,32'h0       ,1, 1,32'h100,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,0,1,32'h00500093,1, 0,32'h100,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,0,0,32'h0       ,1, 0,32'h100,1,32'h00500093));
      vecs.push_back(mk(0,1,32'h200,1,0,32'h0       ,1, 1,32'h104,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,0,32'h0       ,1, 0,32'h200,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,1,32'hDEAD0001,1, 0,32'h200,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,0,32'h0       ,1, 1,32'h200,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,0,1,32'h11      ,0, 0,32'h200,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,0,0,32'h0       ,0, 0,32'h200,1,32'h11));
      vecs.push_back(mk(0,0,32'h0  ,0,1,32'h99      ,1, 0,32'h200,1,32'h11));
      vecs.push_back(mk(0,0,32'h0  ,1,0,32'h0       ,1, 1,32'h204,0,32'h0));
      vecs.push_back(mk(0,1,32'h300,0,1,32'hBAD1    ,1, 0,32'h204,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,1,0,32'h0       ,1, 1,32'h300,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,0,1,32'h22      ,1, 0,32'h300,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,0,0,32'h0       ,1, 0,32'h300,1,32'h22));
      vecs.push_back(mk(0,0,32'h0  ,1,0,32'h0       ,1, 1,32'h304,0,32'h0));
      vecs.push_back(mk(0,0,32'h0  ,0,1,32'h33      ,1, 0,32'h304,0,32'h0));
      vecs.push_back(mk(0,1,32'h400,0,0,32'h0       ,1, 0,32'h304,1,32'h33));
      vecs.push_back(mk(0,0,32'h0  ,0,0,32'h0       ,1, 1,32'h400,0,32'h0));

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         cyc(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rvalid,
             vecs[i].rdata, vecs[i].ready);
         chk_core(tag, vecs[i].exp_req, vecs[i].exp_pc, vecs[i].exp_valid);
         if (vecs[i].exp_valid || vecs[i].rst)
            chk({tag, ".instr"}, instr, vecs[i].exp_instr);
      end

      // decode back-pressure: 5 stalled cycles in S_HOLD
`ifdef FETCH_PERF_CNT_EN
      exp_stall = 32'd5; exp_fetch = 32'd1;
`else
      exp_stall = 32'd0; exp_fetch = 32'd0;
`endif
      cyc(1,0,32'h0,0,0,32'h0,0);
      chk("stall.rst_cnt", stall_cnt, 32'h0);
      chk("fetch.rst_cnt", fetch_cnt, 32'h0);
      cyc(0,0,32'h0,1,0,32'h0,0);
      chk_core("stall.req", 1'b1, 32'h0, 1'b0);
      cyc(0,0,32'h0,0,1,32'h0000_00A3,0);
      for (int k = 0; k < 5; k++) begin
         cyc(0,0,32'h0,1,0,32'h0,0);
         chk_core($sformatf("stall%0d", k), 1'b0, 32'h0, 1'b1);
         chk($sformatf("stall%0d.instr", k), instr, 32'h0000_00A3);
      end
      cyc(0,0,32'h0,0,0,32'h0,1);
      chk_core("stall.hs", 1'b0, 32'h0, 1'b1);
      cyc(0,0,32'h0,0,0,32'h0,0);
      chk_core("stall.next", 1'b1, 32'h4, 1'b0);
      chk("stall.cnt", stall_cnt, exp_stall);
      chk("fetch.cnt", fetch_cnt, exp_fetch);

      // pc wrap at the top of the address space
      cyc(0,1,32'hFFFF_FFFC,0,0,32'h0,0);
      cyc(0,0,32'h0,1,0,32'h0,0);
      chk_core("wrap.req", 1'b1, 32'hFFFF_FFFC, 1'b0);
      cyc(0,0,32'h0,0,1,32'h55,0);
      cyc(0,0,32'h0,0,0,32'h0,1);
      chk_core("wrap.hold", 1'b0, 32'hFFFF_FFFC, 1'b1);
      chk("wrap.plus4", pc_plus4, 32'h0);
      cyc(0,0,32'h0,0,0,32'h0,0);
      chk_core("wrap.next", 1'b1, 32'h0, 1'b0);

      // reset while waiting for a response; late response must be ignored
      cyc(1,0,32'h0,0,0,32'h0,0);
      cyc(0,0,32'h0,1,0,32'h0,0);
      chk_core("rst.req", 1'b1, 32'h0, 1'b0);
      cyc(1,0,32'h0,0,0,32'h0,0);
      chk_core("rst.mid", 1'b0, RESET_PC_DEFAULT, 1'b0);
      chk("rst.instr", instr, 32'h0);
      cyc(0,0,32'h0,0,1,32'hEE,0);
      chk_core("rst.late", 1'b1, RESET_PC_DEFAULT, 1'b0);
      cyc(0,0,32'h0,1,0,32'h0,0);
      chk_core("rst.req2", 1'b1, RESET_PC_DEFAULT, 1'b0);
      cyc(0,0,32'h0,0,1,32'h44,0);
      chk_core("rst.wait", 1'b0, RESET_PC_DEFAULT, 1'b0);
      cyc(0,0,32'h0,0,0,32'h0,1);
      chk_core("rst.hold", 1'b0, RESET_PC_DEFAULT, 1'b1);
      chk("rst.hold.instr", instr, 32'h44);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
